sp_ram_initiator: RTL and testbench
===================================

SP_RAM_INITIATOR -- requirements
Module: sp_ram_initiator

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, giving the byte-address width of both the core port and the RAM port.
REQ-002 SHALL use a fixed 32-bit data width with 4 byte lanes; there is no DATA_WIDTH parameter.
REQ-003 SHALL run on one clock and use a synchronous, active-high reset, with ports: clk  in  1  clock, all logic on rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 req_i  in  1  core request.
REQ-006 gnt_o  out  1  request accepted this cycle.
REQ-007 addr_i  in  ADDR_WIDTH  byte address, any alignment.
REQ-008 we_i  in  1  1=write, 0=read.
REQ-009 size_i  in  2  0=byte, 1=half, 2=word, 3=treated as word.
REQ-010 wdata_i  in  32  right-aligned write data.
REQ-011 rvalid_o  out  1  one-cycle completion pulse for reads and writes.
REQ-012 rdata_o  out  32  right-aligned, zero-extended read data; 0 when rvalid_o=0 or on write completion.
REQ-013 ram_en_o  out  1  RAM access enable.
REQ-014 ram_addr_o  out  ADDR_WIDTH  RAM byte address, bits [1:0] always 0.
REQ-015 ram_wdata_o  out  32  lane-positioned write data.
REQ-016 ram_we_o  out  1  RAM write enable.
REQ-017 ram_be_o  out  4  RAM byte enables.
REQ-018 ram_rdata_i  in  32  RAM read data, valid the cycle after the access.

Function
REQ-019 FSM states SHALL be IDLE, ACC0, ACC1, RESP.
REQ-020 gnt_o SHALL be req_i AND state==IDLE AND NOT rst; on grant, addr/we/size/wdata SHALL be latched and the state SHALL go to ACC0.
REQ-021 Terms: off=addr[1:0] and nbytes=1/2/4 from size; split SHALL equal (off+nbytes>4), i.e. a half at off 3 or a word at off 1..3.
REQ-022 ACC0 SHALL drive ram_en_o=1, ram_addr_o={addr[AW-1:2],2'b00}, ram_we_o=we, ram_be_o=mask[3:0] and ram_wdata_o=(wdata<<8*off)[31:0], where mask=((1<<nbytes)-1)<<off as 8 bits.
REQ-023 From ACC0 the FSM SHALL go to ACC1 if split, else to RESP.
REQ-024 ACC1 SHALL drive ram_en_o=1, ram_addr_o=word address+4 (modulo 2^ADDR_WIDTH, wrapping to 0), ram_be_o=mask[7:4] and ram_wdata_o=wdata>>8*(4-off); it SHALL capture ram_rdata_i (the ACC0 data) into lo_q and then go to RESP.
REQ-025 RESP SHALL assert rvalid_o=1, return to IDLE, and drive ram_en_o=0.
REQ-026 On a read, rdata_o SHALL be ({hi,lo}>>8*off) masked to nbytes, where: non-split gives lo=ram_rdata_i and hi=0; split gives lo=lo_q and hi=ram_rdata_i.
REQ-027 In IDLE and RESP, ram_en_o, ram_we_o and ram_be_o SHALL be 0, and ram_wdata_o SHALL be 0.
REQ-028 Latency from the grant cycle T SHALL be: non-split rvalid_o at T+2; split rvalid_o at T+3.
REQ-029 The next grant SHALL be possible no earlier than T+3 (non-split) or T+4 (split).
REQ-030 There SHALL be exactly one rvalid_o pulse per grant and none without a grant.
REQ-031 req_i deasserted after grant SHALL NOT affect the transaction in flight.

Reset
REQ-032 While rst=1, the state SHALL be forced to IDLE at the clock edge, gnt_o and rvalid_o SHALL be 0, and all ram_* outputs SHALL be 0 from the following cycle.
REQ-033 Reset asserted in ACC0/ACC1/RESP SHALL abandon the transaction with no rvalid_o pulse; a RAM write already issued in that cycle is not undone.
REQ-034 After rst falls, a request SHALL be grantable in the first cycle.

Verification
REQ-035 Aligned word: write 0xDEADBEEF to 0x0010, then read 0x0010 -> ram_be_o=4'hF on write, rdata_o=0xDEADBEEF at T+2.
REQ-036 Byte at off 2: write 0xA5 to 0x0012 -> ram_be_o=4'b0100 and ram_wdata_o[23:16]=0xA5; reading it back -> rdata_o=0x000000A5.
REQ-037 Split word: write 0x11223344 to 0x0023 -> ACC0 addr 0x0020 with be 4'b1000 and lane3=0x44; ACC1 addr 0x0024 with be 4'b0111 and data 0x00112233; reading 0x0023 -> rdata_o=0x11223344 at T+3.
REQ-038 Split half at the top address 0xFFFF (ADDR_WIDTH=16) -> ACC1 ram_addr_o=0x0000 (wrap) with be 4'b0001.
REQ-039 Back-to-back: req_i held high for 3 non-split reads -> grants at T, T+3, T+6 and rvalid_o at T+2, T+5, T+8.
REQ-040 rst pulsed in ACC1 of a split read -> no rvalid_o, ram_en_o=0 in the next cycle, and a new request is granted in the first cycle after rst falls.

Source files
------------

// File: rtl/sp_ram_initiator.sv
// rtl/sp_ram_initiator.sv - core-to-single-port-RAM bridge for unaligned byte/half/word accesses
// Accesses that cross a word boundary are split into two consecutive RAM cycles.
module sp_ram_initiator #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_i,
  output logic                  gnt_o,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  we_i,
  input  logic [1:0]            size_i,
  input  logic [31:0]           wdata_i,
  output logic                  rvalid_o,
  output logic [31:0]           rdata_o,
  output logic                  ram_en_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [31:0]           ram_wdata_o,
  output logic                  ram_we_o,
  output logic [3:0]            ram_be_o,
  input  logic [31:0]           ram_rdata_i
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC0 = 2'd1;
  localparam logic [1:0] ACC1 = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  logic [1:0]            state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  we_q;
  logic [1:0]            size_q;
  logic [31:0]           wdata_q;
  logic [31:0]           lo_q;

  logic [1:0]            off;
  logic [4:0]            sh;
  logic [2:0]            nbytes;
  logic                  split;
  logic [7:0]            mask;
  logic [31:0]           byte_mask;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic [63:0]           rd_pair;
  logic [31:0]           rd_shift;

  assign off       = addr_q[1:0];
  assign sh        = {off, 3'b000};
  assign word_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign split     = ({1'b0, off} + nbytes) > 3'd4;

  always_comb begin
    nbytes    = 3'd4;
    mask      = 8'h0F;
    byte_mask = 32'hFFFF_FFFF;
    case (size_q)
      2'd0: begin nbytes = 3'd1; mask = 8'h01; byte_mask = 32'h0000_00FF; end
      2'd1: begin nbytes = 3'd2; mask = 8'h03; byte_mask = 32'h0000_FFFF; end
      default: ;
    endcase
    mask = mask << off;
  end

  assign gnt_o    = req_i && (state_q == IDLE) && !rst;
  assign rvalid_o = (state_q == RESP) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      size_q  <= 2'd0;
      wdata_q <= '0;
      lo_q    <= '0;
    end else begin
      case (state_q)
        IDLE: if (req_i) begin
          addr_q  <= addr_i;
          we_q    <= we_i;
          size_q  <= size_i;
          wdata_q <= wdata_i;
          state_q <= ACC0;
        end
        ACC0: state_q <= split ? ACC1 : RESP;
        ACC1: begin
          // ram_rdata_i here is the first (lower) word of the split read
          lo_q    <= ram_rdata_i;
          state_q <= RESP;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    ram_en_o    = 1'b0;
    ram_addr_o  = '0;
    ram_we_o    = 1'b0;
    ram_be_o    = 4'b0000;
    ram_wdata_o = '0;
    case (state_q)
      ACC0: begin
        ram_en_o    = 1'b1;
        ram_addr_o  = word_addr;
        ram_we_o    = we_q;
        ram_be_o    = mask[3:0];
        ram_wdata_o = wdata_q << sh;
      end
      ACC1: begin
        ram_en_o    = 1'b1;
        ram_addr_o  = word_addr + ADDR_WIDTH'(4);
        ram_we_o    = we_q;
        ram_be_o    = mask[7:4];
        ram_wdata_o = wdata_q >> (6'd32 - {1'b0, sh});
      end
      default: ;
    endcase
  end

  assign rd_pair  = split ? {ram_rdata_i, lo_q} : {32'b0, ram_rdata_i};
  assign rd_shift = 32'(rd_pair >> sh);
  assign rdata_o  = (rvalid_o && !we_q) ? (rd_shift & byte_mask) : 32'b0;

endmodule

// File: tb/tb_sp_ram_initiator.sv
// tb/tb_sp_ram_initiator.sv - scoreboard bench for sp_ram_initiator against a byte-level memory model
// Directed cases first, then randomized traffic near address 0 and the top-of-memory wrap.
module tb_sp_ram_initiator;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_i;
  logic        gnt_o;
  logic [15:0] addr_i;
  logic        we_i;
  logic [1:0]  size_i;
  logic [31:0] wdata_i;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        ram_en_o;
  logic [15:0] ram_addr_o;
  logic [31:0] ram_wdata_o;
  logic        ram_we_o;
  logic [3:0]  ram_be_o;
  logic [31:0] ram_rdata_i = '0;

  sp_ram_initiator #(.ADDR_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i),
    .we_i(we_i), .size_i(size_i), .wdata_i(wdata_i), .rvalid_o(rvalid_o),
    .rdata_o(rdata_o), .ram_en_o(ram_en_o), .ram_addr_o(ram_addr_o),
    .ram_wdata_o(ram_wdata_o), .ram_we_o(ram_we_o), .ram_be_o(ram_be_o),
    .ram_rdata_i(ram_rdata_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] mem     [0:65535];
  logic [7:0] ref_mem [0:65535];

  typedef struct { int cyc; logic [31:0] data; } exp_t;
  typedef struct { int cyc; logic [15:0] addr; logic we; logic [3:0] be; logic [31:0] wdata; } acc_t;
  exp_t exp_q[$];
  acc_t acc_q[$];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Single-port RAM: read data appears the cycle after the enabled access
  always @(posedge clk) begin
    if (ram_en_o) begin
      ram_rdata_i <= {mem[int'(ram_addr_o) + 3], mem[int'(ram_addr_o) + 2],
                      mem[int'(ram_addr_o) + 1], mem[int'(ram_addr_o)]};
      for (int i = 0; i < 4; i++)
        if (ram_we_o && ram_be_o[i]) mem[int'(ram_addr_o) + i] <= ram_wdata_o[8*i +: 8];
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (ram_en_o)
      acc_q.push_back('{cyc, ram_addr_o, ram_we_o, ram_be_o, ram_wdata_o});
    else
      check("ram_idle_zero", {ram_we_o, ram_be_o, ram_wdata_o}, 64'd0);
    if (rvalid_o) begin
      if (exp_q.size() == 0) check("spurious_rvalid", 64'd1, 64'd0);
      else begin
        e = exp_q.pop_front();
        check("rvalid_cycle", 64'(cyc), 64'(e.cyc));
        check("rdata", 64'(rdata_o), 64'(e.data));
      end
    end else if (rdata_o !== 32'd0) begin
      check("rdata_idle_zero", 64'(rdata_o), 64'd0);
    end
  end

  // Reference: an access touches nbytes consecutive bytes from addr, wrapping at 64 KiB
  task automatic model_push(input logic [15:0] a, input logic w, input logic [1:0] s,
                            input logic [31:0] d, input int t);
    int nb = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    int off = int'(a[1:0]);
    logic [31:0] v = '0;
    for (int i = 0; i < nb; i++) begin
      if (w) ref_mem[(int'(a) + i) % 65536] = d[8*i +: 8];
      else   v[8*i +: 8] = ref_mem[(int'(a) + i) % 65536];
    end
    exp_q.push_back('{t + ((off + nb > 4) ? 3 : 2), v});
  endtask

  task automatic issue(input logic [15:0] a, input logic w, input logic [1:0] s,
                       input logic [31:0] d, input bit keep, output int t);
    req_i = 1'b1; addr_i = a; we_i = w; size_i = s; wdata_i = d; t = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (gnt_o) begin t = cyc; break; end
      @(posedge clk); #1;
    end
    if (t < 0) check("grant_timeout", 64'd0, 64'd1);
    else begin
      model_push(a, w, s, d, t);
      @(posedge clk); #1;
    end
    if (!keep) req_i = 1'b0;
  endtask

  task automatic idle(input int n);
    req_i = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_done();
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) begin @(posedge clk); #1; end
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int t, t1, t2, t3, c0, n;
    logic [15:0] a;
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 8'(i * 7 + 13);
      ref_mem[i] = 8'(i * 7 + 13);
    end
    rst = 1'b1; req_i = 1'b0; addr_i = '0; we_i = 1'b0; size_i = 2'd0; wdata_i = '0;
    repeat (3) @(posedge clk);
    #1 req_i = 1'b1;
    @(negedge clk);
    check("reset_outputs", {gnt_o, rvalid_o, ram_en_o}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    c0 = cyc;

    // Aligned word write then read
    acc_q.delete();
    issue(16'h0010, 1'b1, 2'd2, 32'hDEADBEEF, 1'b0, t);
    check("first_grant_after_reset", 64'(t), 64'(c0));
    wait_done();
    check("word_acc_count", 64'(acc_q.size()), 64'd1);
    if (acc_q.size() >= 1) check("word_be", 64'(acc_q[0].be), 64'hF);
    issue(16'h0010, 1'b0, 2'd2, 32'h0, 1'b0, t);
    wait_done();

    // Byte at offset 2
    acc_q.delete();
    issue(16'h0012, 1'b1, 2'd0, 32'h000000A5, 1'b0, t);
    wait_done();
    check("byte_acc_count", 64'(acc_q.size()), 64'd1);
    if (acc_q.size() >= 1) begin
      check("byte_be", 64'(acc_q[0].be), 64'h4);
      check("byte_lane2", 64'(acc_q[0].wdata[23:16]), 64'hA5);
    end
    issue(16'h0012, 1'b0, 2'd0, 32'h0, 1'b0, t);
    wait_done();

    // Split word at 0x23
    acc_q.delete();
    issue(16'h0023, 1'b1, 2'd2, 32'h11223344, 1'b0, t);
    wait_done();
    check("split_acc_count", 64'(acc_q.size()), 64'd2);
    if (acc_q.size() >= 2) begin
      check("split_acc0", {acc_q[0].addr, acc_q[0].be, acc_q[0].wdata[31:24]}, {16'h0020, 4'b1000, 8'h44});
      check("split_acc1", {acc_q[1].addr, acc_q[1].be, acc_q[1].wdata}, {16'h0024, 4'b0111, 32'h00112233});
      check("split_acc_cycles", {32'(acc_q[0].cyc - t), 32'(acc_q[1].cyc - t)}, {32'd1, 32'd2});
    end
    issue(16'h0023, 1'b0, 2'd2, 32'h0, 1'b0, t);
    wait_done();

    // Split half at the top address wraps to word 0
    acc_q.delete();
    issue(16'hFFFF, 1'b1, 2'd1, 32'h0000BEEF, 1'b0, t);
    wait_done();
    check("wrap_acc_count", 64'(acc_q.size()), 64'd2);
    if (acc_q.size() >= 2) begin
      check("wrap_acc0", {acc_q[0].addr, acc_q[0].be}, {16'hFFFC, 4'b1000});
      check("wrap_acc1", {acc_q[1].addr, acc_q[1].be}, {16'h0000, 4'b0001});
    end
    issue(16'hFFFF, 1'b0, 2'd1, 32'h0, 1'b0, t);
    wait_done();

    // Back-to-back non-split reads with req held high
    issue(16'h0010, 1'b0, 2'd2, 32'h0, 1'b1, t1);
    issue(16'h0012, 1'b0, 2'd1, 32'h0, 1'b1, t2);
    issue(16'h0021, 1'b0, 2'd0, 32'h0, 1'b0, t3);
    check("b2b_spacing", {32'(t2 - t1), 32'(t3 - t2)}, {32'd3, 32'd3});
    wait_done();

    // Reset during ACC1 of a split read abandons it
    req_i = 1'b1; addr_i = 16'h0023; we_i = 1'b0; size_i = 2'd2;
    @(negedge clk);
    check("rst_test_grant", 64'(gnt_o), 64'd1);
    @(posedge clk); #1 req_i = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    c0 = cyc;
    acc_q.delete();
    issue(16'h0010, 1'b0, 2'd2, 32'h0, 1'b0, t);
    check("grant_after_rst", 64'(t), 64'(c0));
    n = 0;
    foreach (acc_q[i]) if (acc_q[i].cyc == c0) n++;
    check("ram_en_after_rst", 64'(n), 64'd0);
    wait_done();

    // Randomized traffic
    for (int k = 0; k < 300; k++) begin
      a = ($urandom_range(0, 3) == 0) ? 16'(16'hFFF8 + $urandom_range(0, 7))
                                      : 16'($urandom_range(0, 63));
      issue(a, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom,
            1'($urandom_range(0, 1)), t);
      if (!req_i) idle($urandom_range(0, 2));
    end
    idle(1);
    wait_done();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
